// File: rtl/icache_direct.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : icache_direct                                                    |
// | Brief    : Direct-mapped read-only instruction cache with whole-block       |
// |            refill, flush and hit/miss performance counters.                 |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module icache_direct #(
  parameter int LINES       = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic [31:0] instr_o,
  output logic        hit_o,
  output logic        stall_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_valid_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] C_LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

  state_t             r_state;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag_arr [LINES];
  logic [31:0]        r_data    [LINES][BLOCK_WORDS];
  logic [IDX_W-1:0]   r_idx_l;
  logic [TAG_W-1:0]   r_tag_l;
  logic [OFF_W-1:0]   r_beat;
  logic               r_flush_pend;
  logic               r_mem_req;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_hit_cnt;
  logic [31:0]        r_miss_cnt;

  logic [OFF_W-1:0]   w_off;
  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_beat_fire;
  logic               w_last_beat;
  logic               w_unused_addr;

  assign w_off = addr_i[OFF_W+1:2];
  assign w_idx = addr_i[OFF_W+IDX_W+1:OFF_W+2];
  assign w_tag = addr_i[31 -: TAG_W];
  assign w_unused_addr = ^addr_i[1:0];

  assign w_hit       = (r_state == ST_IDLE) && r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
  assign w_beat_fire = (r_state == ST_REFILL) && mem_valid_i;
  assign w_last_beat = w_beat_fire && (r_beat == C_LAST_BEAT);

  assign hit_o      = w_hit;
  assign instr_o    = w_hit ? r_data[w_idx][w_off] : 32'h0000_0000;
  assign stall_o    = (req_i && !w_hit) || (r_state != ST_IDLE);
  assign mem_req_o  = r_mem_req;
  assign mem_addr_o = r_mem_addr;
  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;

  // Storage arrays carry no reset; only the valid bits decide what is usable.
  always_ff @(posedge clk_i) begin
    if (w_beat_fire) begin
      r_data[r_idx_l][r_beat] <= mem_rdata_i;
    end
    if (w_last_beat) begin
      r_tag_arr[r_idx_l] <= r_tag_l;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_valid      <= '0;
      r_idx_l      <= '0;
      r_tag_l      <= '0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_i && w_hit) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
          end
          // A flush wins over a coincident miss: no refill is launched.
          if (flush_i) begin
            r_valid <= '0;
          end else if (req_i && !w_hit) begin
            r_idx_l    <= w_idx;
            r_tag_l    <= w_tag;
            r_beat     <= '0;
            r_miss_cnt <= r_miss_cnt + 32'd1;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}, 2'b00};
            r_state    <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (flush_i) begin
            r_flush_pend <= 1'b1;
          end
          if (mem_valid_i) begin
            if (r_beat == C_LAST_BEAT) begin
              if (r_flush_pend || flush_i) begin
                r_valid <= '0;
              end else begin
                r_valid[r_idx_l] <= 1'b1;
              end
              r_flush_pend <= 1'b0;
              r_mem_req    <= 1'b0;
              r_beat       <= '0;
              r_state      <= ST_IDLE;
            end else begin
              r_beat     <= r_beat + 1'b1;
              r_mem_addr <= {r_tag_l, r_idx_l, r_beat + 1'b1, 2'b00};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_icache_direct                                                 |
// | Brief    : Directed self-checking bench for icache_direct.                  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_icache_direct;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic [31:0] addr_i;
  logic [31:0] instr_o;
  logic        hit_o;
  logic        stall_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_valid_i;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  int slow_cnt = 0;
  bit slow_mode = 1'b0;

  icache_direct #(.LINES(16), .BLOCK_WORDS(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .instr_o     (instr_o),
    .hit_o       (hit_o),
    .stall_o     (stall_o),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_valid_i (mem_valid_i),
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory contents: a distinct word derived from each address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  assign mem_rdata_i = mem_word(mem_addr_o);

  // Memory responder: zero-wait, or one beat every third refill cycle.
  initial begin
    mem_valid_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o) begin
        slow_cnt++;
        mem_valid_i = slow_mode ? (slow_cnt % 3 == 0) : 1'b1;
      end else begin
        slow_cnt    = 0;
        mem_valid_i = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic exp_hit);
    addr_i = a;
    #1;
    check_eq(tag, 32'(hit_o), 32'(exp_hit));
  endtask

  // Fetch one address; on a miss wait (bounded) for the hit and check the penalty.
  task automatic do_fetch(input logic [31:0] a, input bit is_miss, input int exp_edges);
    int n;
    req_i  = 1'b1;
    addr_i = a;
    #1;
    check_eq("lookup_hit", 32'(hit_o), 32'(!is_miss));
    check_eq("lookup_stall", 32'(stall_o), 32'(is_miss));
    if (is_miss) begin
      exp_miss++;
      n = 0;
      while (!hit_o && n < 100) begin
        step();
        n++;
      end
      check_eq("miss_penalty", 32'(n), 32'(exp_edges));
    end
    check_eq("instr", instr_o, mem_word(a));
    exp_hits++;
    step();
    req_i = 1'b0;
  endtask

  initial begin
    int n;
    rst_i   = 1'b1;
    req_i   = 1'b0;
    addr_i  = 32'h0;
    flush_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_mem_req", 32'(mem_req_o), 32'd0);
    check_eq("rst_mem_addr", mem_addr_o, 32'h0);
    check_eq("rst_hit_cnt", hit_cnt_o, 32'd0);
    check_eq("rst_miss_cnt", miss_cnt_o, 32'd0);
    check_eq("rst_hit", 32'(hit_o), 32'd0);
    rst_i = 1'b0;
    step();

    // Cold miss at 0x0: beats 0x0,0x4,0x8,0xC, hit on the 6th cycle.
    req_i  = 1'b1;
    addr_i = 32'h0;
    #1;
    check_eq("cold_stall", 32'(stall_o), 32'd1);
    check_eq("cold_hit", 32'(hit_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("cold_mem_req", 32'(mem_req_o), 32'd1);
      check_eq("cold_mem_addr", mem_addr_o, 32'(4 * k));
    end
    step();
    check_eq("cold_hit6", 32'(hit_o), 32'd1);
    check_eq("cold_stall6", 32'(stall_o), 32'd0);
    check_eq("cold_instr", instr_o, mem_word(32'h0));
    check_eq("cold_miss_cnt", miss_cnt_o, 32'd1);
    check_eq("cold_mem_req_off", 32'(mem_req_o), 32'd0);
    step();
    exp_miss = 1;
    exp_hits = 1;

    // Rest of the block hits back-to-back.
    for (int k = 1; k < 4; k++) begin
      addr_i = 32'(4 * k);
      #1;
      check_eq("blk_hit", 32'(hit_o), 32'd1);
      check_eq("blk_stall", 32'(stall_o), 32'd0);
      check_eq("blk_instr", instr_o, mem_word(32'(4 * k)));
      step();
      exp_hits++;
    end
    req_i = 1'b0;
    check_eq("blk_hit_cnt", hit_cnt_o, 32'd4);

    // Conflict eviction on index 0.
    do_fetch(32'h100, 1'b1, 5);
    do_fetch(32'h10C, 1'b0, 0);
    do_fetch(32'h000, 1'b1, 5);
    check_eq("conflict_miss_cnt", miss_cnt_o, 32'd3);

    // Slow memory: one beat every third cycle, address holds in between.
    slow_mode = 1'b1;
    req_i  = 1'b1;
    addr_i = 32'h40;
    exp_miss++;
    #1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_eq("slow_mem_addr", mem_addr_o, 32'h40 + 32'(4 * ((k - 1) / 3)));
    end
    step();
    check_eq("slow_hit13", 32'(hit_o), 32'd1);
    check_eq("slow_instr", instr_o, mem_word(32'h40));
    step();
    exp_hits++;
    req_i = 1'b0;
    slow_mode = 1'b0;
    do_fetch(32'h44, 1'b0, 0);
    do_fetch(32'h48, 1'b0, 0);
    do_fetch(32'h4C, 1'b0, 0);

    // Flush pulse during a refill: line left invalid, all lines cleared.
    req_i  = 1'b1;
    addr_i = 32'h80;
    exp_miss++;
    step();
    req_i   = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    n = 0;
    while (mem_req_o && n < 50) begin
      step();
      n++;
    end
    check_eq("fl_refill_done", 32'(mem_req_o), 32'd0);
    peek("fl_line_invalid", 32'h80, 1'b0);
    peek("fl_other_invalid", 32'h40, 1'b0);
    do_fetch(32'h80, 1'b1, 5);
    check_eq("fl_miss_cnt", miss_cnt_o, 32'(exp_miss));

    // Flush in IDLE: hit still seen in the flush cycle, everything misses after.
    do_fetch(32'h000, 1'b1, 5);
    do_fetch(32'h040, 1'b1, 5);
    peek("pre_flush_0", 32'h000, 1'b1);
    peek("pre_flush_80", 32'h080, 1'b1);
    req_i   = 1'b1;
    addr_i  = 32'h000;
    flush_i = 1'b1;
    #1;
    check_eq("flush_cycle_hit", 32'(hit_o), 32'd1);
    step();
    exp_hits++;
    addr_i = 32'h010;
    #1;
    check_eq("flush_miss_seen", 32'(hit_o), 32'd0);
    step();
    flush_i = 1'b0;
    req_i   = 1'b0;
    check_eq("flush_no_refill", 32'(mem_req_o), 32'd0);
    check_eq("flush_miss_cnt", miss_cnt_o, 32'(exp_miss));
    check_eq("flush_hit_cnt", hit_cnt_o, 32'(exp_hits));
    peek("post_flush_0", 32'h000, 1'b0);
    peek("post_flush_40", 32'h040, 1'b0);
    peek("post_flush_80", 32'h080, 1'b0);

    // Asynchronous reset after the third beat of a refill.
    req_i  = 1'b1;
    addr_i = 32'hC0;
    #1;
    repeat (4) @(posedge clk_i);
    #2;
    check_eq("pre_rst_mem_req", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_eq("arst_mem_req", 32'(mem_req_o), 32'd0);
    check_eq("arst_hit_cnt", hit_cnt_o, 32'd0);
    check_eq("arst_miss_cnt", miss_cnt_o, 32'd0);
    req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    exp_hits = 0;
    exp_miss = 0;
    peek("arst_line_invalid", 32'hC0, 1'b0);
    do_fetch(32'hC0, 1'b1, 5);
    check_eq("final_miss_cnt", miss_cnt_o, 32'(exp_miss));
    check_eq("final_hit_cnt", hit_cnt_o, 32'(exp_hits));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
